// File: rtl/tlul_mem_ctrl.sv
// tlul_mem_ctrl: TL-UL slave front end for a single-port synchronous RAM with
// byte-lane write enables. One Channel A request is accepted at a time. It is
// checked for opcode, size, alignment and byte mask. Accepted requests drive
// the RAM, and exactly one Channel D response is returned.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   A_*                 TL-UL Channel A (request) from the crossbar
//   D_*                 TL-UL Channel D (response) to the crossbar
//   MEM_EN/WE/ADDR      RAM strobe, write enable and word address
//   MEM_WMASK/WDATA     RAM byte write enables and write data
//   MEM_RDATA           RAM read data, valid the cycle after a read strobe
//
// Also contains tlul_mask_chk. It flags a byte mask whose set lanes form one
// contiguous run with a power-of-two length.

// tlul_mask_chk: valid=1 when mask is non-zero and its ones are one
// contiguous run whose length is a power of two.
module tlul_mask_chk #(
    parameter int W = 4
) (
    input  logic [W-1:0] mask,
    output logic         valid
);

    // Population count of the byte mask.
    function automatic int popcount(input logic [W-1:0] m);
        int cnt;
        cnt = 0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + int'(m[i]);
        end
        return cnt;
    endfunction

    logic [W-1:0] low_s;
    int           cnt_s;

    // Isolate the lowest set bit. Adding it to a contiguous run clears the
    // whole run, so any bit that survives the AND marks a gap.
    always_comb begin
        low_s = mask & (~mask + W'(1'b1));
        cnt_s = popcount(mask);
        valid = (mask != '0)
              && (((mask + low_s) & mask) == '0)
              && ((cnt_s & (cnt_s - 1)) == 0);
    end

endmodule

module tlul_mem_ctrl #(
    parameter int W  = 4,
    parameter int AW = 16,
    parameter int SW = 4,
    parameter int ZW = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    A_VALID,
    output logic                    A_READY,
    input  logic [2:0]              A_OPCODE,
    input  logic [ZW-1:0]           A_SIZE,
    input  logic [SW-1:0]           A_SOURCE,
    input  logic [AW-1:0]           A_ADDRESS,
    input  logic [W-1:0]            A_MASK,
    input  logic [8*W-1:0]          A_DATA,
    output logic                    D_VALID,
    input  logic                    D_READY,
    output logic [2:0]              D_OPCODE,
    output logic [ZW-1:0]           D_SIZE,
    output logic [SW-1:0]           D_SOURCE,
    output logic                    D_DENIED,
    output logic [8*W-1:0]          D_DATA,
    output logic                    MEM_EN,
    output logic                    MEM_WE,
    output logic [AW-$clog2(W)-1:0] MEM_ADDR,
    output logic [W-1:0]            MEM_WMASK,
    output logic [8*W-1:0]          MEM_WDATA,
    input  logic [8*W-1:0]          MEM_RDATA
);

    localparam int DW = 8 * W;
    localparam int LW = $clog2(W);
    localparam int MW = AW - LW;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] D_ACK       = 3'd0;
    localparam logic [2:0] D_ACK_DATA  = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RCAP  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Lanes a full access of 2^size bytes at this address would cover.
    function automatic logic [W-1:0] exp_mask(input logic [ZW-1:0] size,
                                              input logic [AW-1:0] addr);
        logic [W-1:0] m;
        int           off;
        int           nb;
        m   = '0;
        off = int'(addr & AW'(W - 1));
        nb  = int'(32'd1 << size);
        for (int i = 0; i < W; i++) begin
            if ((i >= off) && (i < off + nb)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    state_t          state_r;
    logic            a_ready_r;
    logic            d_valid_r;
    logic [2:0]      d_opcode_r;
    logic [ZW-1:0]   d_size_r;
    logic [SW-1:0]   d_source_r;
    logic            d_denied_r;
    logic [DW-1:0]   d_data_r;
    logic            mem_en_r;
    logic            mem_we_r;
    logic [MW-1:0]   mem_addr_r;
    logic [W-1:0]    mem_wmask_r;
    logic [DW-1:0]   mem_wdata_r;

    state_t          nxt_state_s;
    logic            nxt_a_ready_s;
    logic            nxt_d_valid_s;
    logic [2:0]      nxt_d_opcode_s;
    logic [ZW-1:0]   nxt_d_size_s;
    logic [SW-1:0]   nxt_d_source_s;
    logic            nxt_d_denied_s;
    logic [DW-1:0]   nxt_d_data_s;
    logic            nxt_mem_en_s;
    logic            nxt_mem_we_s;
    logic [MW-1:0]   nxt_mem_addr_s;
    logic [W-1:0]    nxt_mem_wmask_s;
    logic [DW-1:0]   nxt_mem_wdata_s;

    logic [W-1:0]    exp_mask_s;
    logic [AW-1:0]   align_s;
    logic            size_bad_s;
    logic            misalign_s;
    logic            op_deny_s;
    logic            deny_s;
    logic            chk_valid_s;

    // The request is judged in the acceptance cycle. The checker therefore
    // looks at the mask being latched, so its verdict is captured with it.
    tlul_mask_chk #(.W(W)) u_mask_chk (
        .mask  (A_MASK),
        .valid (chk_valid_s)
    );

    // Request legality: size, alignment and the per-opcode mask rules.
    always_comb begin
        exp_mask_s = exp_mask(A_SIZE, A_ADDRESS);
        align_s    = AW'((32'd1 << A_SIZE) - 32'd1);
        size_bad_s = (int'(A_SIZE) > LW);
        misalign_s = ((A_ADDRESS & align_s) != '0);
        case (A_OPCODE)
            OP_PUT_FULL, OP_GET: op_deny_s = (A_MASK != exp_mask_s);
            OP_PUT_PART:         op_deny_s = !chk_valid_s
                                          || ((A_MASK & ~exp_mask_s) != '0);
            default:             op_deny_s = 1'b1;
        endcase
        deny_s = size_bad_s | misalign_s | op_deny_s;
    end

    // Next-state and next-output logic. Every output is the registered
    // copy of these values.
    always_comb begin
        nxt_state_s     = state_r;
        nxt_a_ready_s   = a_ready_r;
        nxt_d_valid_s   = d_valid_r;
        nxt_d_opcode_s  = d_opcode_r;
        nxt_d_size_s    = d_size_r;
        nxt_d_source_s  = d_source_r;
        nxt_d_denied_s  = d_denied_r;
        nxt_d_data_s    = d_data_r;
        nxt_mem_en_s    = 1'b0;
        nxt_mem_we_s    = 1'b0;
        nxt_mem_addr_s  = mem_addr_r;
        nxt_mem_wmask_s = mem_wmask_r;
        nxt_mem_wdata_s = mem_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (A_VALID && a_ready_r) begin
                    nxt_a_ready_s  = 1'b0;
                    nxt_d_opcode_s = (A_OPCODE == OP_GET) ? D_ACK_DATA : D_ACK;
                    nxt_d_size_s   = A_SIZE;
                    nxt_d_source_s = A_SOURCE;
                    nxt_d_denied_s = deny_s;
                    nxt_d_data_s   = '0;
                    if (deny_s) begin
                        nxt_state_s   = ST_RESP;
                        nxt_d_valid_s = 1'b1;
                    end else if (A_OPCODE == OP_GET) begin
                        nxt_state_s     = ST_READ;
                        nxt_mem_en_s    = 1'b1;
                        nxt_mem_addr_s  = A_ADDRESS[AW-1:LW];
                        nxt_mem_wmask_s = '0;
                        nxt_mem_wdata_s = '0;
                    end else begin
                        nxt_state_s     = ST_WRITE;
                        nxt_mem_en_s    = 1'b1;
                        nxt_mem_we_s    = 1'b1;
                        nxt_mem_addr_s  = A_ADDRESS[AW-1:LW];
                        nxt_mem_wmask_s = A_MASK;
                        nxt_mem_wdata_s = A_DATA;
                    end
                end else begin
                    nxt_a_ready_s = 1'b1;
                end
            end
            ST_WRITE: begin
                nxt_state_s   = ST_RESP;
                nxt_d_valid_s = 1'b1;
            end
            ST_READ: begin
                nxt_state_s = ST_RCAP;
            end
            ST_RCAP: begin
                nxt_state_s   = ST_RESP;
                nxt_d_data_s  = MEM_RDATA;
                nxt_d_valid_s = 1'b1;
            end
            ST_RESP: begin
                if (D_READY) begin
                    nxt_state_s   = ST_IDLE;
                    nxt_d_valid_s = 1'b0;
                    nxt_a_ready_s = 1'b1;
                end else begin
                    nxt_state_s = ST_RESP;
                end
            end
            default: begin
                nxt_state_s   = ST_IDLE;
                nxt_a_ready_s = 1'b1;
                nxt_d_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            a_ready_r   <= 1'b1;
            d_valid_r   <= 1'b0;
            d_opcode_r  <= 3'd0;
            d_size_r    <= '0;
            d_source_r  <= '0;
            d_denied_r  <= 1'b0;
            d_data_r    <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wmask_r <= '0;
            mem_wdata_r <= '0;
        end else begin
            state_r     <= nxt_state_s;
            a_ready_r   <= nxt_a_ready_s;
            d_valid_r   <= nxt_d_valid_s;
            d_opcode_r  <= nxt_d_opcode_s;
            d_size_r    <= nxt_d_size_s;
            d_source_r  <= nxt_d_source_s;
            d_denied_r  <= nxt_d_denied_s;
            d_data_r    <= nxt_d_data_s;
            mem_en_r    <= nxt_mem_en_s;
            mem_we_r    <= nxt_mem_we_s;
            mem_addr_r  <= nxt_mem_addr_s;
            mem_wmask_r <= nxt_mem_wmask_s;
            mem_wdata_r <= nxt_mem_wdata_s;
        end
    end

    // Handshake and RAM strobes are masked while RST is high. This stops a
    // write already on the RAM pins from committing in the reset cycle. It
    // also stops a half-finished transaction from handshaking.
    assign A_READY   = a_ready_r & ~RST;
    assign D_VALID   = d_valid_r & ~RST;
    assign MEM_EN    = mem_en_r & ~RST;
    assign MEM_WE    = mem_we_r & ~RST;
    assign D_OPCODE  = d_opcode_r;
    assign D_SIZE    = d_size_r;
    assign D_SOURCE  = d_source_r;
    assign D_DENIED  = d_denied_r;
    assign D_DATA    = d_data_r;
    assign MEM_ADDR  = mem_addr_r;
    assign MEM_WMASK = mem_wmask_r;
    assign MEM_WDATA = mem_wdata_r;

endmodule

// File: doc/tlul_mem_ctrl.md
Name: tlul_mem_ctrl

Overview:
- TL-UL slave front end sequencing a single-port synchronous RAM with byte-lane write enables.
- Accepts one Channel A request at a time, validates opcode, size, alignment and byte mask, drives the RAM, and returns exactly one Channel D response.
- Instantiates the team's power-of-2 contiguous mask checker on the latched mask.
- Sits between the TL-UL crossbar port and the tlul_mem RAM macro.

Parameters:
W, 4, bytes per beat; power of 2, >= 1; data width DW = 8*W.
AW, 16, TL-UL byte address width; RAM word address = A_ADDRESS[AW-1:log2(W)].
SW, 4, A_SOURCE/D_SOURCE width.
ZW, 2, A_SIZE/D_SIZE width.

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
A_VALID  in  1  channel A valid
A_READY  out  1  channel A ready
A_OPCODE  in  3  0=PutFullData, 1=PutPartialData, 4=Get
A_SIZE  in  ZW  log2 of bytes
A_SOURCE  in  SW  requester id
A_ADDRESS  in  AW  byte address
A_MASK  in  W  byte lanes
A_DATA  in  DW  write data
D_VALID  out  1  channel D valid
D_READY  in  1  channel D ready
D_OPCODE  out  3  0=AccessAck, 1=AccessAckData
D_SIZE  out  ZW  echo of A_SIZE
D_SOURCE  out  SW  echo of A_SOURCE
D_DENIED  out  1  request rejected
D_DATA  out  DW  read data; zero for writes and denied requests
MEM_EN  out  1  RAM enable
MEM_WE  out  1  RAM write enable
MEM_ADDR  out  AW-log2(W)  RAM word address
MEM_WMASK  out  W  byte write enables
MEM_WDATA  out  DW  write data
MEM_RDATA  in  DW  read data, valid the cycle after MEM_EN with MEM_WE=0

Behaviour:
- Interface: single clock CLK; RST is synchronous, active-high.
- Reset: state IDLE. A_READY=1. D_VALID, D_DENIED, MEM_EN, MEM_WE=0. D_DATA, D_OPCODE, D_SIZE, D_SOURCE, MEM_ADDR, MEM_WMASK, MEM_WDATA=0.
- RST asserted mid-transaction aborts it: no response is issued, and a pending RAM write is not performed in the reset cycle.
- States:
  - IDLE: A_READY=1. On A_VALID&A_READY, latch all A fields.
    - Denied -> RESP.
    - Put -> WRITE.
    - Get -> READ.
  - WRITE: MEM_EN=1, MEM_WE=1, MEM_WMASK=latched mask -> RESP.
  - READ: MEM_EN=1, MEM_WE=0 -> RCAP.
  - RCAP: capture MEM_RDATA into D_DATA -> RESP.
  - RESP: D_VALID=1; all D outputs stay stable until D_READY. On D_VALID&D_READY -> IDLE, D_VALID=0.
- A_READY=0 in every state except IDLE. There is no pipelining and at most one transaction in flight.
- Expected mask E = ((1<<2^A_SIZE)-1) << A_ADDRESS[log2(W)-1:0], truncated to W bits.
- Denied when any of the following holds:
  - opcode not in {0,1,4};
  - 2^A_SIZE > W;
  - A_ADDRESS not aligned to 2^A_SIZE;
  - opcode 0 or 4 and mask != E;
  - opcode 1 and mask checker VALID=0;
  - opcode 1 and (mask & ~E) != 0.
- Denied requests never assert MEM_EN. They respond with D_DENIED=1, D_DATA=0, and D_OPCODE = 1 for Get, otherwise 0.
- Successful responses: D_DENIED=0; D_OPCODE = 1 for Get, 0 for Put.
- Latency, with acceptance in cycle t and D_READY held high:
  - Put: MEM write in t+1, D_VALID in t+2.
  - Get: MEM_EN in t+1, data captured in t+2, D_VALID in t+3.
  - Denied: D_VALID in t+1.
- Back-to-back: the next request is accepted the cycle after the D handshake; A_VALID held during RESP is not consumed.
- D_READY low for N cycles stalls in RESP; D outputs do not change.
- MEM_EN is a single-cycle pulse per access.

Test Plan:
- W=4. Put opcode 0, addr 0x10, size 2, mask 0xF, data 0xDEADBEEF.
  -> MEM_EN=MEM_WE=1, MEM_ADDR=4, MEM_WMASK=0xF one cycle later; AccessAck, D_DENIED=0 at t+2.
- Get addr 0x10, size 2, mask 0xF, MEM_RDATA=0xDEADBEEF.
  -> D_OPCODE=1, D_DATA=0xDEADBEEF at t+3; D_SOURCE echoed.
- PutPartial addr 0x12, size 1, mask 0xC.
  -> MEM_WMASK=0xC.
- PutPartial with mask 0x5 (checker invalid).
  -> no MEM_EN; D_DENIED=1 at t+1.
- Get addr 0x11, size 1 (misaligned); then opcode 2.
  -> both D_DENIED=1; Get response has D_OPCODE=1, D_DATA=0; opcode 2 response has D_OPCODE=0.
- Hold D_READY=0 for 5 cycles with A_VALID=1 throughout.
  -> D outputs stable, A_READY=0, second request accepted the cycle after the handshake.
- Assert RST during WRITE.
  -> no MEM_EN in the reset cycle, no response; all outputs at reset values next cycle.
